seatbelt_reminder: RTL and testbench

SEATBELT_REMINDER -- requirements
Module: seatbelt_reminder

---
 rtl/seatbelt_reminder.sv | 167 ++++++++++++++++
 tb/tb_seatbelt_reminder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seatbelt_reminder.sv
// -----------------------------------------------------------------------------
// seatbelt_reminder
//   Seatbelt warning controller. When the vehicle is running and any seat is
//   in violation, it runs a chime phase: a solid light plus the chime. It then
//   drops to a blink phase with the light only. A new violation that appears
//   during blink or chime starts a fresh chime phase.
//
//   Violation vector: v[0] = ~belt[0] (the driver always counts as present),
//                     v[i] = occ[i] & ~belt[i] for i >= 1.
//
// Handshake / timing: there is no valid/ready handshake. The inputs are level
//   signals sampled on every rising clk edge. Every output is a flop, so an
//   input change shows up on the outputs exactly one clock later.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   ignition   1 = vehicle running, 0 = idle
//   belt       per-seat buckled flags (bit 0 = driver)
//   occ        per-seat occupied flags (bit 0 ignored)
//   sbl        seatbelt warning light
//   chime      audible chime enable
//   unbelted   per-seat violation indicator
//   dbg_state  current FSM state (0 IDLE, 1 OK, 2 CHIME, 3 BLINK)
// -----------------------------------------------------------------------------
module seatbelt_reminder #(
  parameter int NUM_SEATS    = 4,
  parameter int CHIME_CYCLES = 1000,
  parameter int BLINK_HALF   = 250
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ignition,
  input  logic [NUM_SEATS-1:0] belt,
  input  logic [NUM_SEATS-1:0] occ,
  output logic                 sbl,
  output logic                 chime,
  output logic [NUM_SEATS-1:0] unbelted,
  output logic [1:0]           dbg_state
);

  localparam int CNT_MAX = (CHIME_CYCLES > BLINK_HALF) ? CHIME_CYCLES : BLINK_HALF;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] CHIME_LAST = CNT_W'(CHIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OK    = 2'd1,
    ST_CHIME = 2'd2,
    ST_BLINK = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SEATS-1:0] prev_v_q, prev_v_d;
  logic                 sbl_q, sbl_d;
  logic                 chime_q, chime_d;
  logic [NUM_SEATS-1:0] unbelted_q, unbelted_d;

  logic [NUM_SEATS-1:0] occ_eff;
  logic [NUM_SEATS-1:0] v;
  logic                 any_v;
  logic                 rise_v;
  logic                 blink_toggle;

  always_comb begin
    // The driver seat is always treated as occupied.
    occ_eff      = {occ[NUM_SEATS-1:1], occ[0] | 1'b1};
    v            = occ_eff & ~belt;
    any_v        = |v;
    rise_v       = |(v & ~prev_v_q);

    state_d      = state_q;
    cnt_d        = cnt_q;
    prev_v_d     = v;
    blink_toggle = 1'b0;

    if (!ignition) begin
      // Clearing prev_v here means violations that are already present at
      // the next turn-on count as new and produce a full chime phase.
      state_d  = ST_IDLE;
      cnt_d    = '0;
      prev_v_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = any_v ? ST_CHIME : ST_OK;
          cnt_d   = '0;
        end
        ST_OK: begin
          if (any_v) begin
            state_d = ST_CHIME;
            cnt_d   = '0;
          end
        end
        ST_CHIME: begin
          // Priority: violation cleared, then new violation, then expiry.
          if (!any_v) begin
            state_d = ST_OK;
            cnt_d   = '0;
          end else if (rise_v) begin
            cnt_d = '0;
          end else if (cnt_q == CHIME_LAST) begin
            state_d = ST_BLINK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_BLINK: begin
          if (!any_v) begin
            state_d = ST_OK;
            cnt_d   = '0;
          end else if (rise_v) begin
            state_d = ST_CHIME;
            cnt_d   = '0;
          end else if (cnt_q == BLINK_LAST) begin
            // End of a half-period: flip the light and time the next half.
            blink_toggle = 1'b1;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // The outputs follow the state being entered, which gives the
    // one-clock response.
    chime_d    = (state_d == ST_CHIME);
    unbelted_d = (state_d != ST_IDLE) ? v : '0;
    unique case (state_d)
      ST_CHIME: sbl_d = 1'b1;
      ST_BLINK: sbl_d = (state_q != ST_BLINK) ? 1'b1 : (sbl_q ^ blink_toggle);
      default:  sbl_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      prev_v_q   <= '0;
      sbl_q      <= 1'b0;
      chime_q    <= 1'b0;
      unbelted_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_v_q   <= prev_v_d;
      sbl_q      <= sbl_d;
      chime_q    <= chime_d;
      unbelted_q <= unbelted_d;
    end
  end

  assign sbl       = sbl_q;
  assign chime     = chime_q;
  assign unbelted  = unbelted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seatbelt_reminder.sv
// -----------------------------------------------------------------------------
// tb_seatbelt_reminder
//   Drives directed scenarios and then random stimulus into seatbelt_reminder
//   (NUM_SEATS=4, CHIME_CYCLES=8, BLINK_HALF=3). A behavioural model tracks
//   the current phase and the time spent in it. For every clock the model
//   pushes the expected {state, sbl, chime, unbelted} into exp_q, and the
//   bench compares it with the DUT one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_seatbelt_reminder;

  localparam int NS = 4;
  localparam int CC = 8;
  localparam int BH = 3;

  localparam int M_IDLE  = 0;
  localparam int M_OK    = 1;
  localparam int M_CHIME = 2;
  localparam int M_BLINK = 3;

  // clock / reset
  logic          clk = 1'b0;
  logic          reset;
  logic          ignition;
  logic [NS-1:0] belt;
  logic [NS-1:0] occ;
  logic          sbl;
  logic          chime;
  logic [NS-1:0] unbelted;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  seatbelt_reminder #(
    .NUM_SEATS   (NS),
    .CHIME_CYCLES(CC),
    .BLINK_HALF  (BH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ignition (ignition),
    .belt     (belt),
    .occ      (occ),
    .sbl      (sbl),
    .chime    (chime),
    .unbelted (unbelted),
    .dbg_state(dbg_state)
  );

  // scoreboard
  int         n_vec  = 0;
  int         n_miss = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // behavioural model: phase plus time spent in that phase
  int          m_mode = M_IDLE;
  int          m_el   = 0;
  logic [NS-1:0] m_prev = '0;

  task automatic model_edge();
    logic [NS-1:0] v;
    logic [NS-1:0] occ_drv;
    bit            anyv;
    bit            rise;
    logic          e_sbl;
    occ_drv    = occ;
    occ_drv[0] = 1'b1;
    v    = occ_drv & ~belt;
    anyv = (v != 0);
    rise = ((v & ~m_prev) != 0);
    if (reset || !ignition) begin
      m_mode = M_IDLE;
      m_el   = 0;
      m_prev = '0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_mode = anyv ? M_CHIME : M_OK;
          m_el   = 0;
        end
        M_OK: begin
          if (anyv) begin
            m_mode = M_CHIME;
            m_el   = 0;
          end
        end
        M_CHIME: begin
          if (!anyv) begin
            m_mode = M_OK;
            m_el   = 0;
          end else if (rise) begin
            m_el = 0;
          end else if (m_el + 1 >= CC) begin
            m_mode = M_BLINK;
            m_el   = 0;
          end else begin
            m_el++;
          end
        end
        default: begin
          if (!anyv) begin
            m_mode = M_OK;
            m_el   = 0;
          end else if (rise) begin
            m_mode = M_CHIME;
            m_el   = 0;
          end else begin
            m_el++;
          end
        end
      endcase
      m_prev = v;
    end
    if (m_mode == M_CHIME)      e_sbl = 1'b1;
    else if (m_mode == M_BLINK) e_sbl = (((m_el / BH) % 2) == 0);
    else                        e_sbl = 1'b0;
    exp_q.push_back({2'(m_mode), e_sbl, (m_mode == M_CHIME),
                     (m_mode != M_IDLE) ? v : 4'b0000});
  endtask

  // driver: one clock, then compare
  task automatic step();
    logic [7:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    check_eq("state",    32'(dbg_state), 32'(e[7:6]));
    check_eq("sbl",      32'(sbl),       32'(e[5]));
    check_eq("chime",    32'(chime),     32'(e[4]));
    check_eq("unbelted", 32'(unbelted),  32'(e[3:0]));
  endtask

  task automatic drive(input logic ign, input logic [NS-1:0] b, input logic [NS-1:0] o);
    ignition = ign;
    belt     = b;
    occ      = o;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'b1111, 4'b1111);
    repeat (2) step();
    check_eq("reset_out", 32'({sbl, chime, unbelted}), 32'd0);
    reset = 1'b0;

    // all buckled: OK with quiet outputs
    drive(1'b1, 4'b1111, 4'b1111);
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("ok_quiet", 32'({sbl, chime, unbelted}), 32'd0);
    end

    // driver unbuckled: 8-clock chime, then blink 1,1,1,0,0,0,...
    drive(1'b1, 4'b1110, 4'b1111);
    for (int i = 0; i < CC; i++) begin
      step();
      check_eq("chime_phase", 32'({sbl, chime, unbelted}), 32'b110001);
    end
    for (int k = 0; k < 9; k++) begin
      step();
      check_eq("blink_sbl", 32'(sbl), 32'(((k / BH) % 2) == 0));
      check_eq("blink_chime", 32'({chime, unbelted}), 32'b00001);
    end

    // new violation on seat 2 during blink: fresh chime phase
    drive(1'b1, 4'b1010, 4'b1111);
    for (int i = 0; i < CC; i++) begin
      step();
      check_eq("rechime", 32'({sbl, chime, unbelted}), 32'b110101);
    end
    step();
    check_eq("rechime_end", 32'(chime), 32'd0);

    // passenger seats empty and unbuckled: no violation
    drive(1'b1, 4'b0001, 4'b0001);
    repeat (4) step();
    check_eq("empty_seats", 32'({sbl, unbelted}), 32'd0);

    // ignition drop beats buckling in the same cycle
    drive(1'b1, 4'b1110, 4'b1111);
    repeat (3) step();
    drive(1'b0, 4'b1111, 4'b1111);
    step();
    check_eq("ign_drop", 32'({dbg_state, sbl, chime, unbelted}), 32'd0);

    // reset mid-blink, then a full chime with the violation still present
    drive(1'b1, 4'b1110, 4'b1111);
    repeat (12) step();
    reset = 1'b1;
    step();
    check_eq("mid_reset", 32'({sbl, chime, unbelted}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < CC; i++) begin
      step();
      check_eq("post_reset_chime", 32'(chime), 32'd1);
    end
    step();
    check_eq("post_reset_blink", 32'(chime), 32'd0);

    // random stimulus
    for (int i = 0; i < 2000; i++) begin
      reset    = ($urandom_range(0, 199) == 0);
      ignition = ($urandom_range(0, 99) < 97);
      if ($urandom_range(0, 15) == 0)
        belt = ($urandom_range(0, 2) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0)
        occ = 4'($urandom_range(0, 15));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
